// File: rtl/mac_result_drain.sv
// mac_result_drain
//   Consumer end of the mac_16 result interface. A start pulse takes the
//   ROWS x ROW_W result array (latch_array_out) and streams it one row per
//   transfer into the output SRAM write port with a valid/ready handshake.
//   Row i is written to base_addr + i (modulo 2^ADDR_W).
//
//   Optional build macro: DRAIN_SNAPSHOT_EN
//     defined   : the array is copied into an internal snapshot in CAPTURE,
//                 rows are drained from that copy, mac_hold=1 only in CAPTURE.
//     undefined : rows are read live from latch_array_out, mac_hold=1 for
//                 all of CAPTURE and DRAIN.
//
//   Ports
//     clk, rst         clock, asynchronous active-high reset
//     start            one-cycle pulse, accepted only in IDLE
//     base_addr        SRAM address for row 0, sampled on accepted start
//     latch_array_out  result array, row i = [i*ROW_W +: ROW_W]
//     mac_hold         mac_16 must not update latch_array_out
//     sram_wen         write valid
//     sram_ready       SRAM accepts the write this cycle
//     sram_addr        write address
//     sram_wdata       write data
//     busy             drain in progress (state != IDLE)
//     done             one-cycle pulse after the last row is accepted
`timescale 1ns/1ps

module mac_result_drain #(
  parameter int ROWS   = 16,
  parameter int ROW_W  = 384,
  parameter int ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ROWS*ROW_W-1:0] latch_array_out,
  output logic                  mac_hold,
  output logic                  sram_wen,
  input  logic                  sram_ready,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [ROW_W-1:0]      sram_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]            state;
  logic [CNT_W-1:0]      row_cnt;
  logic [ADDR_W-1:0]     base_q;
  logic                  xfer;
  logic [ROWS*ROW_W-1:0] src_array;
  logic [ROW_W-1:0]      row_data;

  assign xfer = (state == S_DRAIN) && sram_ready;

  // Control state: the only registers under reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      row_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CAPTURE;
            row_cnt <= '0;
          end
        end
        S_CAPTURE: state <= S_DRAIN;
        S_DRAIN: begin
          if (xfer) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == LAST_ROW) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Base address is a data register; outputs are gated while not draining,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && start) base_q <= base_addr;
  end

`ifdef DRAIN_SNAPSHOT_EN
  logic [ROWS*ROW_W-1:0] snap;

  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) snap <= latch_array_out;
  end

  assign src_array = snap;
  // Upstream only has to freeze for the single copy cycle.
  assign mac_hold  = (state == S_CAPTURE);
`else
  assign src_array = latch_array_out;
  // Data is read live, so the array must stay frozen until the last beat.
  assign mac_hold  = (state == S_CAPTURE) || (state == S_DRAIN);
`endif

  assign row_data = src_array[int'(row_cnt)*ROW_W +: ROW_W];

  // row_cnt only moves on a transfer, so addr/data hold through stalls.
  assign sram_wen   = (state == S_DRAIN);
  assign sram_addr  = sram_wen ? (base_q + ADDR_W'(row_cnt)) : '0;
  assign sram_wdata = sram_wen ? row_data : '0;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_mac_result_drain.sv
`timescale 1ns/1ps

module tb_mac_result_drain;

  localparam int ROWS   = 16;
  localparam int ROW_W  = 384;
  localparam int ADDR_W = 11;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic [ROWS*ROW_W-1:0] lat;
  logic                  mac_hold;
  logic                  sram_wen;
  logic                  sram_ready;
  logic [ADDR_W-1:0]     sram_addr;
  logic [ROW_W-1:0]      sram_wdata;
  logic                  busy;
  logic                  done;

  mac_result_drain #(.ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .latch_array_out(lat), .mac_hold(mac_hold), .sram_wen(sram_wen),
    .sram_ready(sram_ready), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [ROW_W-1:0] obs,
                       input logic [ROW_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row i, lane l holds the 24-bit value {i, l} (12 bits each).
  function automatic logic [ROW_W-1:0] make_row(input int i);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int l = 0; l < 16; l++) r[l*24 +: 24] = {12'(i), 12'(l)};
    return r;
  endfunction

  task automatic fill(input bit inv);
    for (int i = 0; i < ROWS; i++)
      lat[i*ROW_W +: ROW_W] = inv ? ~make_row(i) : make_row(i);
  endtask

  // Ready pattern driver: mode 0 always ready, mode 1 repeats 1,0,0,1.
  int rdy_mode = 0;
  always @(posedge clk) begin
    int ph;
    #1;
    if (rdy_mode == 1) sram_ready = (ph % 4 == 0) || (ph % 4 == 3);
    else sram_ready = 1'b1;
    ph++;
  end

  // Transfer recorder and stall-stability monitor.
  logic [ADDR_W-1:0] wr_addr [0:63];
  logic [ROW_W-1:0]  wr_data [0:63];
  int                wr_cyc  [0:63];
  int wr_n = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hold_cnt = 0;
  bit stall_prev = 0;
  logic [ADDR_W-1:0] prev_addr;
  logic [ROW_W-1:0]  prev_data;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (mac_hold) hold_cnt++;
      if (stall_prev) begin
        check("stall_wen", ROW_W'(sram_wen), ROW_W'(1));
        check("stall_addr", ROW_W'(sram_addr), ROW_W'(prev_addr));
        check("stall_data", sram_wdata, prev_data);
      end
      if (sram_wen && sram_ready && wr_n < 64) begin
        wr_addr[wr_n] = sram_addr;
        wr_data[wr_n] = sram_wdata;
        wr_cyc[wr_n]  = cyc;
        wr_n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = sram_wen && !sram_ready;
      prev_addr  = sram_addr;
      prev_data  = sram_wdata;
    end
  end

  int start_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    wr_n = 0;
    done_cnt = 0;
    hold_cnt = 0;
  endtask

  // Called 1 time unit after a rising edge; start is high for that cycle.
  task automatic do_start(input logic [ADDR_W-1:0] b);
    start = 1'b1;
    base_addr = b;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  // Returns in the cycle where done is high.
  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) begin
        ok = 1;
        break;
      end
    end
    check(tag, ROW_W'(ok), ROW_W'(1));
  endtask

  task automatic check_drain(input string tag, input logic [ADDR_W-1:0] b,
                             input int off);
    check({tag, "_count"}, ROW_W'(wr_n - off), ROW_W'(16));
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_addr%0d", tag, k), ROW_W'(wr_addr[off + k]),
            ROW_W'(ADDR_W'(b + ADDR_W'(k))));
      check($sformatf("%s_data%0d", tag, k), wr_data[off + k], make_row(k));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    sram_ready = 1'b1;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen",   ROW_W'(sram_wen),  '0);
    check("rst_hold",  ROW_W'(mac_hold),  '0);
    check("rst_addr",  ROW_W'(sram_addr), '0);
    check("rst_wdata", sram_wdata,        '0);
    check("rst_busy",  ROW_W'(busy),      '0);
    check("rst_done",  ROW_W'(done),      '0);
    rst = 1'b0;
    tick();
    check("idle_busy", ROW_W'(busy), '0);

    // 1: plain drain, base 0x010, no backpressure.
    clear();
    do_start(11'h010);
    check("t1_busy_capture", ROW_W'(busy), ROW_W'(1));
    check("t1_wen_capture",  ROW_W'(sram_wen), '0);
    tick();
    check("t1_wen_first", ROW_W'(sram_wen), ROW_W'(1));
    wait_done("t1_done_seen");
    tick();
    check_drain("t1", 11'h010, 0);
    check("t1_latency", ROW_W'(done_cyc - start_cyc), ROW_W'(18));
    check("t1_done_cnt", ROW_W'(done_cnt), ROW_W'(1));
    check("t1_idle", ROW_W'(busy), '0);

    // 2: ready pattern 1,0,0,1 with stall stability checked by the monitor.
    clear();
    rdy_mode = 1;
    tick();
    do_start(11'h040);
    wait_done("t2_done_seen");
    tick();
    rdy_mode = 0;
    check_drain("t2", 11'h040, 0);
    check("t2_done_after_last", ROW_W'(done_cyc - wr_cyc[15]), ROW_W'(1));
    check("t2_done_cnt", ROW_W'(done_cnt), ROW_W'(1));

    // 3: address wrap.
    clear();
    do_start(11'h7F8);
    wait_done("t3_done_seen");
    tick();
    check_drain("t3", 11'h7F8, 0);
    check("t3_addr_top", ROW_W'(wr_addr[7]), ROW_W'(11'h7FF));
    check("t3_addr_wrap", ROW_W'(wr_addr[8]), ROW_W'(11'h000));

    // 4: start during DRAIN is dropped; start right after done is accepted.
    clear();
    do_start(11'h100);
    repeat (4) tick();
    start = 1'b1;
    base_addr = 11'h555;
    tick();
    start = 1'b0;
    wait_done("t4_done_seen");
    tick();
    check_drain("t4a", 11'h100, 0);
    check("t4_done_cnt", ROW_W'(done_cnt), ROW_W'(1));
    do_start(11'h200);
    wait_done("t4b_done_seen");
    tick();
    check_drain("t4b", 11'h200, 16);
    check("t4b_done_cnt", ROW_W'(done_cnt), ROW_W'(2));
    repeat (25) tick();
    check("t4_no_extra_done", ROW_W'(done_cnt), ROW_W'(2));

    // 5: reset after the 5th accepted write.
    clear();
    do_start(11'h300);
    for (int i = 0; i < 100 && wr_n < 5; i++) tick();
    check("t5_five_writes", ROW_W'(wr_n), ROW_W'(5));
    rst = 1'b1;
    #1;
    check("t5_wen",  ROW_W'(sram_wen), '0);
    check("t5_busy", ROW_W'(busy),     '0);
    check("t5_hold", ROW_W'(mac_hold), '0);
    #1;
    rst = 1'b0;
    repeat (25) tick();
    check("t5_no_done", ROW_W'(done_cnt), '0);
    check("t5_writes_stay", ROW_W'(wr_n), ROW_W'(5));
    clear();
    do_start(11'h320);
    wait_done("t5b_done_seen");
    tick();
    check_drain("t5b", 11'h320, 0);

    // 6: data source and mac_hold span.
    clear();
    do_start(11'h400);
`ifdef DRAIN_SNAPSHOT_EN
    for (int i = 0; i < 100 && wr_n < 2; i++) tick();
    fill(1);
`endif
    wait_done("t6_done_seen");
    tick();
    fill(0);
    check_drain("t6", 11'h400, 0);
`ifdef DRAIN_SNAPSHOT_EN
    check("t6_hold_cycles", ROW_W'(hold_cnt), ROW_W'(1));
`else
    check("t6_hold_cycles", ROW_W'(hold_cnt), ROW_W'(17));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
